// File: rtl/count_monitor.sv
// Receive-side checker for a free-running up-counter bus: locks onto the sequence,
// flags out-of-sequence samples and stalls, and keeps a saturating error tally.
module count_monitor #(
  parameter int WIDTH       = 4,
  parameter int MAX_VAL     = 15,
  parameter int STALL_LIMIT = 8,
  parameter int ERR_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [0:WIDTH-1]   count_in,
  input  logic               clr_err,
  output logic               locked,
  output logic               err_pulse,
  output logic               stall,
  output logic [ERR_W-1:0]   err_count,
  output logic [0:WIDTH-1]   last_good
);

  localparam int               HOLD_W   = $clog2(STALL_LIMIT) + 1;
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(STALL_LIMIT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_TRACK = 2'd2,
    S_LOST  = 2'd3
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_prev;
  logic [HOLD_W-1:0] r_hold;
  logic              r_miss;

  logic [WIDTH-1:0]  w_sample;
  logic [WIDTH-1:0]  w_exp;
  logic              w_in_range;
  logic              w_match;
  logic              w_repeat;
  logic              w_err;
  logic [HOLD_W-1:0] w_hold_inc;
  logic [ERR_W-1:0]  w_err_next;

  // Leftmost bit is the MSB on both sides, so a plain copy keeps the numeric value.
  assign w_sample = count_in;

  if (MAX_VAL >= (2 ** WIDTH) - 1) begin : g_full_range
    assign w_in_range = 1'b1;
  end else begin : g_part_range
    assign w_in_range = (w_sample <= MAX_V);
  end

  // Expected successor, sample classification and next error tally.
  always_comb begin
    w_exp      = {WIDTH{1'b0}};
    w_err      = 1'b0;
    w_err_next = err_count;
    if (r_prev == MAX_V) begin
      w_exp = {WIDTH{1'b0}};
    end else begin
      w_exp = r_prev + {{(WIDTH-1){1'b0}}, 1'b1};
    end
    w_match    = (w_sample == w_exp);
    w_repeat   = (w_sample == r_prev);
    w_hold_inc = (r_hold == HOLD_TOP) ? r_hold : r_hold + {{(HOLD_W-1){1'b0}}, 1'b1};
    case (r_state)
      S_SYNC:  w_err = en & ~w_in_range;
      S_TRACK: w_err = en & ~w_match & ~w_repeat;
      default: w_err = 1'b0;
    endcase
    // A clear coinciding with an error leaves exactly that one error counted.
    if (clr_err) begin
      w_err_next = w_err ? {{(ERR_W-1){1'b0}}, 1'b1} : {ERR_W{1'b0}};
    end else if (w_err && (err_count != ERR_MAX)) begin
      w_err_next = err_count + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      w_err_next = err_count;
    end
  end

  // Monitor FSM with registered flags; the error tally and last_good survive en=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_prev    <= {WIDTH{1'b0}};
      r_hold    <= {HOLD_W{1'b0}};
      r_miss    <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      stall     <= 1'b0;
      err_count <= {ERR_W{1'b0}};
      last_good <= {WIDTH{1'b0}};
    end else begin
      err_pulse <= w_err;
      err_count <= w_err_next;
      if (!en) begin
        r_state <= S_IDLE;
        r_hold  <= {HOLD_W{1'b0}};
        r_miss  <= 1'b0;
        locked  <= 1'b0;
        stall   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_SYNC;
            locked  <= 1'b0;
            stall   <= 1'b0;
          end
          S_SYNC: begin
            stall <= 1'b0;
            if (w_in_range) begin
              r_prev    <= w_sample;
              last_good <= count_in;
              r_hold    <= {HOLD_W{1'b0}};
              r_miss    <= 1'b0;
              r_state   <= S_TRACK;
              locked    <= 1'b1;
            end else begin
              r_state <= S_SYNC;
              locked  <= 1'b0;
            end
          end
          S_TRACK: begin
            if (w_match) begin
              r_prev    <= w_sample;
              last_good <= count_in;
              r_hold    <= {HOLD_W{1'b0}};
              r_miss    <= 1'b0;
              stall     <= 1'b0;
            end else if (w_repeat) begin
              r_hold <= w_hold_inc;
              r_miss <= 1'b0;
              stall  <= (w_hold_inc == HOLD_TOP);
            end else begin
              // Re-anchor on the glitch value so a single bad sample costs one error.
              if (w_in_range) begin
                r_prev <= w_sample;
              end else begin
                r_prev <= r_prev;
              end
              r_hold <= {HOLD_W{1'b0}};
              stall  <= 1'b0;
              if (r_miss) begin
                r_state <= S_LOST;
                r_miss  <= 1'b0;
                locked  <= 1'b0;
              end else begin
                r_miss <= 1'b1;
              end
            end
          end
          S_LOST: begin
            r_state <= S_SYNC;
            r_hold  <= {HOLD_W{1'b0}};
            locked  <= 1'b0;
            stall   <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            locked  <= 1'b0;
            stall   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: a vector table for the default instance and a
// MAX_VAL=9 instance, plus a hand-written saturation sequence.
module tb_count_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       m_rst_n, m_en, m_clr;
  logic [0:3] m_cin;
  logic       m_locked, m_ep, m_stall;
  logic [7:0] m_ec;
  logic [0:3] m_lg;

  logic       n_rst_n, n_en, n_clr;
  logic [0:3] n_cin;
  logic       n_locked, n_ep, n_stall;
  logic [7:0] n_ec;
  logic [0:3] n_lg;

  count_monitor dut (
    .clk(clk), .rst_n(m_rst_n), .en(m_en), .count_in(m_cin), .clr_err(m_clr),
    .locked(m_locked), .err_pulse(m_ep), .stall(m_stall), .err_count(m_ec), .last_good(m_lg)
  );

  count_monitor #(.WIDTH(4), .MAX_VAL(9), .STALL_LIMIT(8), .ERR_W(8)) dut9 (
    .clk(clk), .rst_n(n_rst_n), .en(n_en), .count_in(n_cin), .clr_err(n_clr),
    .locked(n_locked), .err_pulse(n_ep), .stall(n_stall), .err_count(n_ec), .last_good(n_lg)
  );

  typedef struct {
    int sel;
    int rst_n, en, clr, cin;
    int locked, ep, stall, ec, lg;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(int sel, int rst_n, int en, int clr, int cin,
                              int locked, int ep, int stall, int ec, int lg);
    vec_t v;
    v.sel = sel; v.rst_n = rst_n; v.en = en; v.clr = clr; v.cin = cin;
    v.locked = locked; v.ep = ep; v.stall = stall; v.ec = ec; v.lg = lg;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    m_rst_n = 1'b0; m_en = 1'b0; m_clr = 1'b0; m_cin = 4'd0;
    n_rst_n = 1'b0; n_en = 1'b0; n_clr = 1'b0; n_cin = 4'd0;

    // default instance: reset, lock and full wrap
    add(0, 0,0,0, 0,  0,0,0,0,0);
    add(0, 1,1,0, 0,  0,0,0,0,0);
    for (int v = 0; v <= 15; v++) add(0, 1,1,0, v, 1,0,0,0,v);
    add(0, 1,1,0, 0,  1,0,0,0,0);
    add(0, 1,1,0, 1,  1,0,0,0,1);
    // single glitch: 5,6,9,10,11
    for (int v = 2; v <= 6; v++) add(0, 1,1,0, v, 1,0,0,0,v);
    add(0, 1,1,0, 9,  1,1,0,1,6);
    add(0, 1,1,0, 10, 1,0,0,1,10);
    add(0, 1,1,0, 11, 1,0,0,1,11);
    // clear alone, then two consecutive errors -> LOST -> SYNC -> relock
    add(0, 1,1,1, 12, 1,0,0,0,12);
    add(0, 1,1,0, 3,  1,1,0,1,12);
    add(0, 1,1,0, 7,  0,1,0,2,12);
    add(0, 1,1,0, 12, 0,0,0,2,12);
    add(0, 1,1,0, 13, 1,0,0,2,13);
    add(0, 1,1,0, 14, 1,0,0,2,14);
    // walk to 4, hold it 10 samples, stall from the 8th, drop after 5
    add(0, 1,1,0, 15, 1,0,0,2,15);
    for (int v = 0; v <= 3; v++) add(0, 1,1,0, v, 1,0,0,2,v);
    for (int k = 1; k <= 10; k++) add(0, 1,1,0, 4, 1,0,(k >= 8) ? 1 : 0,2,4);
    add(0, 1,1,0, 5,  1,0,0,2,5);
    add(0, 1,1,0, 6,  1,0,0,2,6);
    // en drop keeps tally and last_good
    add(0, 1,0,0, 7,  0,0,0,2,6);
    add(0, 1,1,0, 9,  0,0,0,2,6);
    add(0, 1,1,0, 9,  1,0,0,2,9);
    add(0, 1,1,0, 10, 1,0,0,2,10);
    // one-cycle reset mid-TRACK with en held high
    add(0, 0,1,0, 11, 0,0,0,0,0);
    add(0, 1,1,0, 12, 0,0,0,0,0);
    add(0, 1,1,0, 13, 1,0,0,0,13);
    add(0, 1,1,0, 14, 1,0,0,0,14);
    // MAX_VAL=9 instance
    add(1, 0,0,0, 0,  0,0,0,0,0);
    add(1, 1,1,0, 0,  0,0,0,0,0);
    add(1, 1,1,0, 8,  1,0,0,0,8);
    add(1, 1,1,0, 9,  1,0,0,0,9);
    add(1, 1,1,0, 0,  1,0,0,0,0);
    add(1, 1,1,0, 3,  1,1,0,1,0);
    for (int v = 4; v <= 9; v++) add(1, 1,1,0, v, 1,0,0,1,v);
    add(1, 1,1,1, 10, 1,1,0,1,9);
    add(1, 1,1,0, 0,  1,0,0,1,0);

    foreach (vq[i]) begin
      if (vq[i].sel == 0) begin
        m_rst_n = vq[i].rst_n[0]; m_en = vq[i].en[0]; m_clr = vq[i].clr[0]; m_cin = 4'(vq[i].cin);
      end else begin
        n_rst_n = vq[i].rst_n[0]; n_en = vq[i].en[0]; n_clr = vq[i].clr[0]; n_cin = 4'(vq[i].cin);
      end
      @(posedge clk);
      #1;
      if (vq[i].sel == 0) begin
        chk($sformatf("v%0d.locked", i),    int'(m_locked), vq[i].locked);
        chk($sformatf("v%0d.err_pulse", i), int'(m_ep),     vq[i].ep);
        chk($sformatf("v%0d.stall", i),     int'(m_stall),  vq[i].stall);
        chk($sformatf("v%0d.err_count", i), int'(m_ec),     vq[i].ec);
        chk($sformatf("v%0d.last_good", i), int'(m_lg),     vq[i].lg);
      end else begin
        chk($sformatf("v%0d.locked", i),    int'(n_locked), vq[i].locked);
        chk($sformatf("v%0d.err_pulse", i), int'(n_ep),     vq[i].ep);
        chk($sformatf("v%0d.stall", i),     int'(n_stall),  vq[i].stall);
        chk($sformatf("v%0d.err_count", i), int'(n_ec),     vq[i].ec);
        chk($sformatf("v%0d.last_good", i), int'(n_lg),     vq[i].lg);
      end
    end

    // default instance still tracks at prev=14: alternate glitch/accept past saturation
    begin
      int p;
      int e;
      p = 14;
      for (int i = 0; i < 270; i++) begin
        e = (p + 2) % 16;
        m_cin = 4'(e);
        @(posedge clk); #1;
        chk($sformatf("sat%0d.err_pulse", i), int'(m_ep), 1);
        chk($sformatf("sat%0d.err_count", i), int'(m_ec), (i + 1 > 255) ? 255 : i + 1);
        p = (e + 1) % 16;
        m_cin = 4'(p);
        @(posedge clk); #1;
        chk($sformatf("sat%0d.locked", i), int'(m_locked), 1);
      end
      m_clr = 1'b1;
      m_cin = 4'((p + 1) % 16);
      @(posedge clk); #1;
      m_clr = 1'b0;
      chk("sat_clear.err_count", int'(m_ec), 0);
      chk("sat_clear.last_good", int'(m_lg), (p + 1) % 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
